// File: rtl/led_pkg.sv
// ---------------------------------------------------------------------------
// led_pkg
// Shared definitions for the LED PWM driver and its prescaler.
//   PWM_BITS_DEF  : default width of the duty value and PWM counter
//   PRESCALE_DEF  : default prescaler terminal count (tick every N+1 clocks)
//   DUTY_FULL     : all-ones duty at the default width (solid-on LED)
//   duty_state_t  : handshake FSM states (IDLE, PENDING)
// ---------------------------------------------------------------------------
package led_pkg;

  localparam int PWM_BITS_DEF = 8;
  localparam int PRESCALE_DEF = 47;

  localparam logic [PWM_BITS_DEF-1:0] DUTY_FULL = '1;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } duty_state_t;

endpackage

// File: rtl/led_prescaler.sv
// ---------------------------------------------------------------------------
// led_prescaler
// Free-running divider producing a one-cycle tick every PRESCALE+1 clocks.
// Shared by other timing blocks in top.
// Ports:
//   clk  : system clock
//   rstn : asynchronous active-low reset
//   tick : high in the cycle the counter sits at PRESCALE (every cycle when
//          PRESCALE is 0)
// ---------------------------------------------------------------------------
module led_prescaler #(
  parameter int PRESCALE = 47
) (
  input  logic clk,
  input  logic rstn,
  output logic tick
);

  localparam int CW = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE);

  logic [CW-1:0] r_count;

  assign tick = (r_count == LAST);

  // Count 0..PRESCALE and wrap on the tick cycle. With PRESCALE=0 the counter
  // never leaves 0, so tick stays high.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count <= '0;
    end else if (tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

endmodule

// File: rtl/led_pwm_driver.sv
// ---------------------------------------------------------------------------
// led_pwm_driver
// PWM brightness generator for one board LED. New duty values arrive over a
// valid/ready handshake and are applied only at the PWM period boundary so the
// LED never glitches mid-period.
// Ports:
//   clk         : system clock
//   rstn        : asynchronous active-low reset
//   enable      : 0 forces led low; counters and handshake keep running
//   duty        : requested duty value (PWM_BITS wide)
//   duty_valid  : duty is presented
//   duty_ready  : block can accept a duty value
//   led         : registered PWM output
//   period_tick : one-cycle pulse on the first cycle of each PWM period
// Build option:
//   LED_BREATHE_EN : an internal triangle ramp drives the active duty, the
//                    duty input is ignored and duty_ready is held at 0.
// ---------------------------------------------------------------------------
module led_pwm_driver
  import led_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEF,
  parameter int PRESCALE = PRESCALE_DEF
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                enable,
  input  logic [PWM_BITS-1:0] duty,
  input  logic                duty_valid,
  output logic                duty_ready,
  output logic                led,
  output logic                period_tick
);

  localparam logic [PWM_BITS-1:0] FULL = '1;

  logic                w_tick;
  logic                w_wrap;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [PWM_BITS-1:0] r_active_duty;
  logic                r_led;
  logic                r_period_tick;

  led_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rstn (rstn),
    .tick (w_tick)
  );

  // The last tick of a period; duty updates and the period pulse key off it.
  assign w_wrap = w_tick && (r_pwm_cnt == FULL);

  // PWM position within the period, advancing once per prescaler tick.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pwm_cnt <= '0;
    end else if (w_tick) begin
      r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
    end
  end

`ifdef LED_BREATHE_EN

  logic r_dir_up;
  logic w_unused_inputs;

  assign w_unused_inputs = ^{duty, duty_valid};
  assign duty_ready      = 1'b0;

  // Triangle ramp: one step per period, turning around at all-ones and at 0
  // so each end value is held for exactly one period.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_active_duty <= '0;
      r_dir_up      <= 1'b1;
    end else if (w_wrap) begin
      if (r_dir_up) begin
        if (r_active_duty == FULL) begin
          r_dir_up      <= 1'b0;
          r_active_duty <= r_active_duty - PWM_BITS'(1);
        end else begin
          r_active_duty <= r_active_duty + PWM_BITS'(1);
        end
      end else begin
        if (r_active_duty == '0) begin
          r_dir_up      <= 1'b1;
          r_active_duty <= r_active_duty + PWM_BITS'(1);
        end else begin
          r_active_duty <= r_active_duty - PWM_BITS'(1);
        end
      end
    end
  end

`else

  duty_state_t         r_state;
  duty_state_t         w_state_next;
  logic [PWM_BITS-1:0] r_shadow_duty;
  logic                w_accept;

  // Handshake state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and ready. A valid landing on a wrap cycle while IDLE only
  // fills the shadow; the transfer waits for the following wrap.
  always_comb begin
    w_state_next = r_state;
    duty_ready   = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        duty_ready = 1'b1;
        if (duty_valid) begin
          w_accept     = 1'b1;
          w_state_next = PENDING;
        end
      end
      PENDING: begin
        if (w_wrap) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Shadow captures on accept; active duty only changes at a period boundary.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_shadow_duty <= '0;
      r_active_duty <= '0;
    end else begin
      if (w_accept) begin
        r_shadow_duty <= duty;
      end
      if ((r_state == PENDING) && w_wrap) begin
        r_active_duty <= r_shadow_duty;
      end
    end
  end

`endif

  // Output compare, registered. All-ones duty is special-cased so the LED has
  // no dark cycle at the top of the count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_led         <= 1'b0;
      r_period_tick <= 1'b0;
    end else begin
      r_led         <= enable && ((r_pwm_cnt < r_active_duty) || (r_active_duty == FULL));
      r_period_tick <= w_wrap;
    end
  end

  assign led         = r_led;
  assign period_tick = r_period_tick;

endmodule
